// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with bounded grant hold time.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   req      in   [7:0] request vector, bit i held high while requester i wants/uses the resource
//   grant    out  [7:0] registered one-hot (or zero) grant
//   grant_id out  [2:0] registered index of the current / most recent grant
//   busy     out  registered OR of grant
//   any_req  out  combinational OR of req
//   timeout  out  registered one-cycle pulse when a grant is revoked by the hold limit
//
// Every grant is followed by exactly one zero cycle (GAP) before the next
// arbitration. The pointer moves to winner+1, so the last holder drops to
// lowest priority.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       busy,
  output logic       any_req,
  output logic       timeout
);

  localparam logic [7:0] MAX_HOLD_C = MAX_HOLD[7:0];

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_id_q, grant_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;

  assign any_req = |req;

  // First set request searching ptr, ptr+1, ... (mod 8).
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr_q + i[2:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          grant_d    = 8'd1 << winner;
          grant_id_d = winner;
          ptr_d      = winner + 3'd1;
          cnt_d      = 8'd1;
          state_d    = GRANT;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release wins over a coincident hold-limit expiry.
        if (!req[grant_id_q]) begin
          grant_d = '0;
          state_d = GAP;
        end else if (cnt_q >= MAX_HOLD_C) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share the same stimulus and are each compared every cycle against a
// holder/hold-count model of the arbitration rules.
module tb_rr_arbiter_8;

  logic       clk;
  logic       reset;
  logic [7:0] req;

  logic [7:0] grant_a, grant_b;
  logic [2:0] grant_id_a, grant_id_b;
  logic       busy_a, busy_b;
  logic       any_req_a, any_req_b;
  logic       timeout_a, timeout_b;

  int checks;
  int failures;

  // Model state per instance: current holder (-1 none), cycles held,
  // next search start, most recent winner, timeout pulse.
  int mh      [2];
  int holder  [2];
  int held    [2];
  int start   [2];
  int last_id [2];
  int to_m    [2];

  rr_arbiter_8 #(.MAX_HOLD(4)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant_a),
    .grant_id (grant_id_a),
    .busy     (busy_a),
    .any_req  (any_req_a),
    .timeout  (timeout_a)
  );

  rr_arbiter_8 #(.MAX_HOLD(1)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant_b),
    .grant_id (grant_id_b),
    .busy     (busy_b),
    .any_req  (any_req_b),
    .timeout  (timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic [7:0] r, input logic rs);
    int w;
    if (rs) begin
      holder[k] = -1; held[k] = 0; start[k] = 0; last_id[k] = 0; to_m[k] = 0;
    end else if (holder[k] >= 0) begin
      to_m[k] = 0;
      if (r[holder[k]] == 1'b0) begin
        holder[k] = -1;
      end else if (held[k] == mh[k]) begin
        holder[k] = -1;
        to_m[k] = 1;
      end else begin
        held[k] = held[k] + 1;
      end
    end else begin
      to_m[k] = 0;
      if (r != 8'h00) begin
        w = -1;
        for (int j = 0; j < 8; j++) begin
          if (w < 0 && r[(start[k] + j) % 8]) w = (start[k] + j) % 8;
        end
        holder[k]  = w;
        last_id[k] = w;
        start[k]   = (w + 1) % 8;
        held[k]    = 1;
      end
    end
  endtask

  function automatic logic [7:0] exp_grant(input int k);
    return (holder[k] >= 0) ? (8'd1 << holder[k]) : 8'h00;
  endfunction

  // One clock: drive after negedge, check any_req, clock, update model, check outputs.
  task automatic cyc(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req   = r;
    reset = rs;
    #1;
    check("any_req_a", 32'(any_req_a), 32'(r != 8'h00));
    check("any_req_b", 32'(any_req_b), 32'(r != 8'h00));
    @(posedge clk);
    model_step(0, r, rs);
    model_step(1, r, rs);
    #1;
    check("grant_a",    32'(grant_a),    32'(exp_grant(0)));
    check("grant_id_a", 32'(grant_id_a), 32'(last_id[0]));
    check("busy_a",     32'(busy_a),     32'(holder[0] >= 0));
    check("timeout_a",  32'(timeout_a),  32'(to_m[0]));
    check("grant_b",    32'(grant_b),    32'(exp_grant(1)));
    check("grant_id_b", 32'(grant_id_b), 32'(last_id[1]));
    check("busy_b",     32'(busy_b),     32'(holder[1] >= 0));
    check("timeout_b",  32'(timeout_b),  32'(to_m[1]));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] flip;
    int         to_count;
    checks   = 0;
    failures = 0;
    mh[0] = 4;
    mh[1] = 1;
    for (int k = 0; k < 2; k++) begin
      holder[k] = -1; held[k] = 0; start[k] = 0; last_id[k] = 0; to_m[k] = 0;
    end
    req   = 8'h00;
    reset = 1'b1;

    // Reset state
    cyc(8'h00, 1'b1);
    cyc(8'hFF, 1'b1);
    check("rst_grant", 32'(grant_a), 32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);

    // Single requester
    cyc(8'h01, 1'b0);
    check("single_grant", 32'(grant_a), 32'h01);
    check("single_busy",  32'(busy_a),  32'h1);
    cyc(8'h00, 1'b0);
    check("single_release", 32'(grant_a), 32'h00);
    check("single_release_to", 32'(timeout_a), 32'h0);

    // Pointer wrap: search starts at 1, so requester 7 beats 0
    cyc(8'h81, 1'b0);
    check("wrap_grant7", 32'(grant_a), 32'h80);
    for (int i = 0; i < 6; i++) cyc(8'h81, 1'b0);
    check("wrap_grant0", 32'(grant_a), 32'h01);

    // Full load rotation, count revocations on MAX_HOLD=4 instance
    cyc(8'h00, 1'b1);
    to_count = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(8'hFF, 1'b0);
      if (timeout_a) to_count++;
    end
    check("rotation_timeouts", 32'(to_count), 32'd9);

    // Coincident release and hold limit on requester 2
    cyc(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(8'h04, 1'b0);
    check("coinc_held", 32'(grant_a), 32'h04);
    cyc(8'h00, 1'b0);
    check("coinc_grant", 32'(grant_a), 32'h00);
    check("coinc_to",    32'(timeout_a), 32'h0);

    // Reset mid-grant to requester 5
    cyc(8'h00, 1'b1);
    cyc(8'h20, 1'b0);
    cyc(8'h20, 1'b0);
    check("mid_grant5", 32'(grant_a), 32'h20);
    cyc(8'h20, 1'b1);
    check("mid_rst_grant", 32'(grant_a), 32'h00);
    check("mid_rst_id",    32'(grant_id_a), 32'h0);
    cyc(8'h21, 1'b0);
    check("mid_after_rst", 32'(grant_a), 32'h01);

    // Idle then single request
    for (int i = 0; i < 5; i++) cyc(8'h00, 1'b0);
    cyc(8'h10, 1'b0);
    check("idle_then_req", 32'(grant_a), 32'h10);

    // Random phase: sticky requests with occasional flips and resets
    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      flip = 8'h00;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 7) == 0);
      r = r ^ flip;
      cyc(r, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have a parameter MAX_HOLD, default 15: the maximum number of consecutive cycles a grant is held (legal range 1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 req  input  8  request vector; bit i is requester i and is held high while requester i wants or uses the resource.
REQ-006 grant  output  8  registered grant vector, one-hot or all-zero.
REQ-007 grant_id  output  3  registered binary index of the current grant, or of the most recent grant when grant is zero.
REQ-008 busy  output  1  registered, equal to the OR of grant.
REQ-009 any_req  output  1  combinational 8-way OR of req.
REQ-010 timeout  output  1  registered one-cycle pulse marking a grant revoked by the hold limit.

Function
REQ-011 The FSM SHALL have the states IDLE, GRANT and GAP.
REQ-012 A round-robin pointer ptr[2:0] SHALL set priority: the search order is ptr, ptr+1, ..., ptr+7 (mod 8), and the first set req bit wins.
REQ-013 When the FSM is in IDLE or GAP and any_req=1 at an edge, at that edge the FSM SHALL:
- load grant with onehot(winner);
- load grant_id with the winner;
- set ptr to (winner+1) mod 8;
- set the hold counter to 1;
- enter GRANT.
REQ-014 Grant latency SHALL be one cycle: req first sampled high at edge N gives grant visible after edge N.
REQ-015 In IDLE or GAP with any_req=0, grant SHALL stay 0 and the FSM SHALL enter or stay in IDLE.
REQ-016 In GRANT with req[grant_id]=1 and counter<MAX_HOLD, grant SHALL be held and the counter SHALL increment by 1.
REQ-017 In GRANT with req[grant_id]=0 sampled (release), the next edge SHALL clear grant, enter GAP, and leave timeout=0.
REQ-018 In GRANT with counter==MAX_HOLD and req[grant_id]=1, the next edge SHALL clear grant, set timeout=1 for exactly one cycle, and enter GAP.
REQ-019 If release and the hold limit coincide, the event SHALL be treated as a release, with timeout=0.
REQ-020 GAP SHALL last exactly one cycle with grant=0, and arbitration SHALL occur at the GAP exit edge, so consecutive grants are separated by exactly one idle cycle.
REQ-021 During GRANT, changes on non-granted req bits SHALL be ignored.
REQ-022 The pointer update SHALL place the timed-out or released requester at lowest priority for the next arbitration.
REQ-023 The hold counter SHALL be 8 bits wide and SHALL never wrap, because the counter stops at MAX_HOLD.
REQ-024 grant SHALL never have more than one bit set.

Reset
REQ-025 With reset=1 at an edge, the following SHALL hold after that edge regardless of state, including mid-grant:
- grant=0, grant_id=0, busy=0, timeout=0;
- ptr=0, counter=0, state=IDLE.
REQ-026 reset SHALL take priority over all other inputs.
REQ-027 The first arbitration after reset SHALL start its search at index 0.

Verification
REQ-028 Single requester: reset, then req=8'h01 -> after 1 edge grant=8'h01, grant_id=0, busy=1; req=0 -> next edge grant=0, busy=0, timeout=0.
REQ-029 Full load rotation: MAX_HOLD=4, req=8'hFF held -> grants 8'h01, 8'h02, ..., 8'h80, 8'h01, each lasting 4 cycles, each followed by a 1-cycle zero gap, with timeout pulsing once per revocation.
REQ-030 Pointer wrap: after requester 0 is granted and released, req=8'h81 -> grant=8'h80 (search starts at 1); after that release with req=8'h81 still high -> grant=8'h01.
REQ-031 Coincident release and hold limit: MAX_HOLD=3, requester 2 drops req in the cycle the counter reaches 3 -> grant clears, timeout stays 0.
REQ-032 Reset mid-grant: reset during a grant to requester 5 -> outputs zero after the edge; then req=8'h21 -> grant=8'h01.
REQ-033 Idle: req=0 -> any_req=0, grant=0 indefinitely; setting req=8'h10 -> any_req=1 in the same cycle, grant=8'h10 after 1 edge.
